// File: rtl/dmem_responder_if.sv
// Data-memory request/response channel between the core (master) and a
// memory-side responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        err;

  modport master (
    output req_valid, req_addr, req_we, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised DMEM target: byte-masked stores, fixed-latency loads, one
// outstanding load. Optional access checking under MEM_ACCESS_CHECK_EN.
module dmem_responder #(
  parameter  int DEPTH = 16384,
  parameter  int LAT   = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int             CW       = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'((LAT > 1) ? LAT - 2 : 0);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   rsp_data_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          acc;
  logic          illegal;

  assign idx = bus.req_addr[AW+1:2];
  // req_ready already carries !rst, so a store landing on the reset edge is dropped
  assign acc = bus.req_valid & bus.req_ready;

`ifdef MEM_ACCESS_CHECK_EN
  logic err_q;
  assign illegal = (|bus.req_addr[31:AW+2]) |
                   ((|bus.req_addr[1:0]) & (|bus.req_wmask));

  always_ff @(posedge clk) begin
    if (rst)                err_q <= 1'b0;
    else if (acc & illegal) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
  assign illegal = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (acc && bus.req_we && !illegal) begin
      for (int b = 0; b < 4; b++)
        if (bus.req_wmask[b]) mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (acc && !bus.req_we) begin
          // load data is sampled at accept; illegal loads still complete with zero
          rsp_data_q <= illegal ? 32'h0 : mem[idx];
          if (LAT == 1) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = !rst && (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;

endmodule
